// File: rtl/sumador_reg_if.sv
// ---------------------------------------------------------------------------
// sumador_reg_if
//   Operand/result bundle for the registered adder.
//   master : drives in_valid, A, B; observes Z and the flags.
//   slave  : the adder itself; consumes operands, produces Z and the flags.
// Signals
//   in_valid  operands valid this cycle
//   A, B      WIDTH-bit operands (unsigned or two's complement)
//   Z         registered sum, low WIDTH bits
//   carry     registered unsigned carry-out
//   overflow  registered signed overflow
//   zero      1 when Z == 0
//   out_valid Z and the flags hold a new result this cycle
// ---------------------------------------------------------------------------
interface sumador_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Z;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, A, B,
        input  Z, carry, overflow, zero, out_valid
    );

    modport slave (
        input  in_valid, A, B,
        output Z, carry, overflow, zero, out_valid
    );
endinterface

// File: rtl/sumador_reg.sv
// ---------------------------------------------------------------------------
// sumador_reg
//   Registered two-operand adder for the MIPS datapath (PC+4, branch target).
//   Z = (A + B) mod 2^WIDTH, registered one cycle after in_valid, together
//   with carry-out, signed overflow and a zero flag.
//   The sum uses 4-bit carry-lookahead groups; group generate/propagate
//   terms feed a flattened group-level lookahead unit, so no carry ripples
//   from group to group.
// Ports
//   clk    in  single clock, rising edge
//   reset  in  synchronous, active-high; clears Z/flags, drops out_valid
//   bus    sumador_reg_if.slave (in_valid, A, B -> Z, carry, overflow,
//          zero, out_valid)
// Parameters
//   WIDTH  operand/result width, multiple of 4, minimum 4
// ---------------------------------------------------------------------------
module sumador_reg #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    sumador_reg_if.slave  bus
);

    localparam int NG = WIDTH / 4;

    // Group generate/propagate of a 4-bit slice: {G, P}.
    function automatic logic [1:0] grp_gp(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] g;
        logic [3:0] p;
        logic       gg;
        g  = a & b;
        p  = a ^ b;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gg, &p};
    endfunction

    // Sum of a 4-bit slice with in-group lookahead carries.
    function automatic logic [3:0] grp_sum(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin);
        logic [2:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g    = a[2:0] & b[2:0];
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return p ^ c;
    endfunction

    // Group-level lookahead: carry into group k is the OR over every lower
    // group j of G[j] gated by the propagates of all groups between j and k.
    // Written as a sum of products so each carry is two logic levels deep in
    // the group terms rather than a chain. Carry-in to bit 0 is zero.
    function automatic logic [NG:0] grp_carries(input logic [NG-1:0] gg,
                                                input logic [NG-1:0] pp);
        logic [NG:0] c;
        logic        t;
        c = '0;
        for (int k = 1; k <= NG; k++) begin
            for (int j = 0; j < k; j++) begin
                t = gg[j];
                for (int m = j + 1; m < k; m++) begin
                    t = t & pp[m];
                end
                c[k] = c[k] | t;
            end
        end
        return c;
    endfunction

    logic [NG-1:0]    w_grp_g;
    logic [NG-1:0]    w_grp_p;
    logic [NG:0]      w_grp_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        assign {w_grp_g[gi], w_grp_p[gi]} = grp_gp(bus.A[4*gi +: 4], bus.B[4*gi +: 4]);
        assign w_sum[4*gi +: 4] = grp_sum(bus.A[4*gi +: 4], bus.B[4*gi +: 4], w_grp_c[gi]);
    end

    assign w_grp_c = grp_carries(w_grp_g, w_grp_p);
    assign w_carry = w_grp_c[NG];
    // Signed overflow: operands share a sign that the result does not.
    assign w_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);

    logic [WIDTH-1:0] r_z;
    logic             r_carry;
    logic             r_ovf;
    logic             r_valid;

    // Output register: Z/flags load only on in_valid and otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_z     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_z     <= w_sum;
                r_carry <= w_carry;
                r_ovf   <= w_ovf;
            end
        end
    end

    assign bus.Z         = r_z;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_ovf;
    // Decoded from the registered sum so it can never disagree with Z.
    assign bus.zero      = (r_z == '0);
    assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_sumador_reg.sv
// ---------------------------------------------------------------------------
// tb_sumador_reg
//   Scoreboard bench for sumador_reg: each valid add pushes the behavioural
//   result {carry, Z} = A + B plus signed overflow; the entry is popped and
//   compared one cycle later.
// ---------------------------------------------------------------------------
module tb_sumador_reg;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    sumador_reg_if #(.WIDTH(W)) bus_if ();

    sumador_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct packed {
        logic [W-1:0] z;
        logic         c;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Drive a valid add and push the model result.
    task automatic drive_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        exp_t       e;
        s   = {1'b0, a} + {1'b0, b};
        e.z = s[W-1:0];
        e.c = s[W];
        e.o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        sb.push_back(e);
        bus_if.A        = a;
        bus_if.B        = b;
        bus_if.in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus_if.A        = 32'h1234;
        bus_if.B        = 32'h1234;
        bus_if.in_valid = 1'b1;
        step();
        step();
        n_checks++;
        if (bus_if.Z !== '0) begin
            n_fail++;
            $display("FAIL reset_Z got=%h exp=%h", bus_if.Z, 32'h0);
        end
        n_checks++;
        if (bus_if.carry !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_carry got=%b exp=0", bus_if.carry);
        end
        n_checks++;
        if (bus_if.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overflow got=%b exp=0", bus_if.overflow);
        end
        n_checks++;
        if (bus_if.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_zero got=%b exp=1", bus_if.zero);
        end
        n_checks++;
        if (bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got=%b exp=0", bus_if.out_valid);
        end
        reset = 1'b0;
    endtask

    // Table-driven adds: each result checked in full one cycle after issue.
    task automatic run_table(input string name, input logic [W-1:0] ta[3],
                             input logic [W-1:0] tb[3]);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive_add(ta[i], tb[i]);
            step();
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_%0d scoreboard empty", name, i);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (bus_if.Z !== e.z || bus_if.carry !== e.c || bus_if.overflow !== e.o ||
                    bus_if.zero !== (e.z == '0) || bus_if.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_%0d got Z=%h c=%b o=%b zf=%b v=%b exp Z=%h c=%b o=%b zf=%b v=1",
                             name, i, bus_if.Z, bus_if.carry, bus_if.overflow, bus_if.zero,
                             bus_if.out_valid, e.z, e.c, e.o, (e.z == '0));
                end
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[3];
        logic [W-1:0] tb[3];
        ta = '{32'd5, 32'd5, 32'd3};
        tb = '{32'd0, 32'd17, 32'd17};
        run_table("directed", ta, tb);
        // Independent spot check of the last directed sum.
        n_checks++;
        if (bus_if.Z !== 32'd20 || bus_if.carry !== 1'b0 || bus_if.overflow !== 1'b0 ||
            bus_if.zero !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_last got Z=%0d c=%b o=%b zf=%b exp Z=20 c=0 o=0 zf=0",
                     bus_if.Z, bus_if.carry, bus_if.overflow, bus_if.zero);
        end
    endtask

    task automatic test_hold();
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_if.A = $urandom;
            bus_if.B = $urandom;
            step();
            n_checks++;
            if (bus_if.out_valid !== 1'b0 || bus_if.Z !== 32'd20 || bus_if.carry !== 1'b0 ||
                bus_if.zero !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d got Z=%0d v=%b c=%b zf=%b exp Z=20 v=0 c=0 zf=0",
                         i, bus_if.Z, bus_if.out_valid, bus_if.carry, bus_if.zero);
            end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] ta[3];
        logic [W-1:0] tb[3];
        ta = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        tb = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
        run_table("wrap", ta, tb);
        // Last case: 0x80000000+0x80000000 -> Z=0, carry=1, overflow=1, zero=1.
        n_checks++;
        if (bus_if.Z !== 32'h0 || bus_if.carry !== 1'b1 || bus_if.overflow !== 1'b1 ||
            bus_if.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_min_min got Z=%h c=%b o=%b zf=%b exp Z=0 c=1 o=1 zf=1",
                     bus_if.Z, bus_if.carry, bus_if.overflow, bus_if.zero);
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        // Reset wins over a valid add on the same edge; nothing is pushed.
        bus_if.A        = 32'd100;
        bus_if.B        = 32'd200;
        bus_if.in_valid = 1'b1;
        reset           = 1'b1;
        step();
        n_checks++;
        if (bus_if.Z !== 32'h0 || bus_if.out_valid !== 1'b0 || bus_if.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset got Z=%h v=%b zf=%b exp Z=0 v=0 zf=1",
                     bus_if.Z, bus_if.out_valid, bus_if.zero);
        end
        reset = 1'b0;
        drive_add(32'd100, 32'd200);
        step();
        e = sb.pop_front();
        n_checks++;
        if (bus_if.Z !== e.z || bus_if.Z !== 32'd300 || bus_if.out_valid !== 1'b1 ||
            bus_if.zero !== 1'b0) begin
            n_fail++;
            $display("FAIL after_midreset got Z=%0d v=%b zf=%b exp Z=300 v=1 zf=0",
                     bus_if.Z, bus_if.out_valid, bus_if.zero);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 10000; i++) begin
            drive_add($urandom, $urandom);
            step();
            e = sb.pop_front();
            n_checks++;
            if (bus_if.Z !== e.z || bus_if.carry !== e.c || bus_if.overflow !== e.o ||
                bus_if.zero !== (e.z == '0) || bus_if.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL random_%0d got Z=%h c=%b o=%b zf=%b v=%b exp Z=%h c=%b o=%b zf=%b v=1",
                         i, bus_if.Z, bus_if.carry, bus_if.overflow, bus_if.zero,
                         bus_if.out_valid, e.z, e.c, e.o, (e.z == '0));
            end
        end
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.A        = '0;
        bus_if.B        = '0;
        test_reset();
        test_directed();
        test_hold();
        test_wrap();
        test_reset_midstream();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
